// File: rtl/mux_4_arbiter_nb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_arbiter_nb_pkg                                             |
// | Shared constants for the round-robin 4-to-1 mux arbiter.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mux_4_arbiter_nb_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       idx_t;
  typedef logic             state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

  localparam idx_t REQ_A = 2'd0;
  localparam idx_t REQ_B = 2'd1;
  localparam idx_t REQ_C = 2'd2;
  localparam idx_t REQ_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mux_4_arbiter_nb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_arbiter_nb_if                                              |
// | Requester / downstream bundle for the shared mux arbiter.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mux_4_arbiter_nb_if #(
  parameter int N = 4
);

  logic [3:0]   req;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   S;
  logic [N-1:0] Y;
  logic         out_valid;
  logic         busy;

  // master: requesters plus downstream sink; slave: the arbiter itself
  modport master (
    output req, A, B, C, D, out_ready,
    input  gnt, S, Y, out_valid, busy
  );

  modport slave (
    input  req, A, B, C, D, out_ready,
    output gnt, S, Y, out_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/mux_4_to_1_nb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_to_1_nb                                                    |
// | N-bit 4-to-1 combinational multiplexer.                          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux_4_to_1_nb #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [1:0]   S,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = A;
    case (S)
      2'd0: Y = A;
      2'd1: Y = B;
      2'd2: Y = C;
      2'd3: Y = D;
      default: Y = A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux_4_arbiter_nb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_arbiter_nb                                                 |
// | Round-robin arbiter / burst sequencer owning a shared 4:1 mux.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux_4_arbiter_nb
  import mux_4_arbiter_nb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_4_arbiter_nb_if.slave  bus
);

  localparam cnt_t LAST_BEAT = cnt_t'(MAX_BURST - 1);

  state_t state_q, state_d;
  idx_t   ptr_q,   ptr_d;
  idx_t   s_q,     s_d;
  logic [3:0] gnt_q, gnt_d;
  cnt_t   cnt_q,   cnt_d;

  logic   req_s;
  logic   xfer;
  idx_t   winner;

  // Lowest offset from ptr wins, so scan offsets high-to-low and keep the last hit.
  function automatic idx_t rr_pick(input logic [3:0] r, input idx_t p);
    idx_t idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + idx_t'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(bus.req, ptr_q);
  assign req_s  = bus.req[s_q];
  assign xfer   = (state_q == ST_BURST) && req_s && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_A;
      s_q     <= REQ_A;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          s_d     = winner;
          gnt_d   = 4'b0001 << winner;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // S is left in place on exit so Y keeps following the last owner while idle.
        if (!req_s || (xfer && cnt_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = s_q + 2'd1;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d   = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.S         = s_q;
    bus.busy      = (state_q == ST_BURST);
    bus.out_valid = (state_q == ST_BURST) && req_s;
  end

  mux_4_to_1_nb #(
    .N (N)
  ) u_mux (
    .A (bus.A),
    .B (bus.B),
    .C (bus.C),
    .D (bus.D),
    .S (s_q),
    .Y (bus.Y)
  );

endmodule
`default_nettype wire

// File: tb/tb_mux_4_arbiter_nb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_4_arbiter_nb                                              |
// | Directed self-checking bench for the round-robin mux arbiter.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mux_4_arbiter_nb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mux_4_arbiter_nb_if #(.N(4)) bus4 ();
  mux_4_arbiter_nb_if #(.N(4)) bus2 ();

  mux_4_arbiter_nb #(.N(4), .MAX_BURST(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux_4_arbiter_nb #(.N(4), .MAX_BURST(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus4.req = 4'b0000; bus4.out_ready = 1'b1;
    bus4.A = 4'h1; bus4.B = 4'h9; bus4.C = 4'hC; bus4.D = 4'hD;
    bus2.req = 4'b0000; bus2.out_ready = 1'b1;
    bus2.A = 4'h3; bus2.B = 4'h5; bus2.C = 4'h7; bus2.D = 4'hE;

    // reset values
    tick(); tick();
    chk("rst_gnt",   bus4.gnt, 4'b0000);
    chk("rst_S",     bus4.S, 2'd0);
    chk("rst_busy",  bus4.busy, 1'b0);
    chk("rst_valid", bus4.out_valid, 1'b0);
    chk("rst_Y",     bus4.Y, 4'h1);
    rst = 1'b0;

    // single requester B, full burst of 4, idle cycle, re-grant
    bus4.req = 4'b0010;
    tick();
    chk("b_gnt", bus4.gnt, 4'b0010);
    chk("b_S",   bus4.S, 2'd1);
    for (int b = 0; b < 4; b++) begin
      chk("b_valid", bus4.out_valid, 1'b1);
      chk("b_Y",     bus4.Y, 4'h9);
      chk("b_busy",  bus4.busy, 1'b1);
      tick();
    end
    chk("b_idle_busy", bus4.busy, 1'b0);
    chk("b_idle_gnt",  bus4.gnt, 4'b0000);
    chk("b_idle_val",  bus4.out_valid, 1'b0);
    tick();
    chk("b_regnt", bus4.gnt, 4'b0010);
    bus4.req = 4'b0000;
    #1;
    chk("b_drop_val", bus4.out_valid, 1'b0);
    tick();
    chk("b_drop_busy", bus4.busy, 1'b0);

    // early release by D while A requests
    bus4.req = 4'b1000;
    tick();
    chk("d_gnt", bus4.gnt, 4'b1000);
    chk("d_Y",   bus4.Y, 4'hD);
    chk("d_val", bus4.out_valid, 1'b1);
    tick();
    bus4.req = 4'b0001;
    #1;
    chk("d_drop_val", bus4.out_valid, 1'b0);
    chk("d_drop_gnt", bus4.gnt, 4'b1000);
    tick();
    chk("d_exit_busy", bus4.busy, 1'b0);
    bus4.req = 4'b1111;
    tick();
    chk("d_next_gnt", bus4.gnt, 4'b0001);

    // backpressure on A
    bus4.out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_val", bus4.out_valid, 1'b1);
      chk("bp_Y",   bus4.Y, 4'h1);
      chk("bp_gnt", bus4.gnt, 4'b0001);
      tick();
    end
    bus4.out_ready = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk("bp_beat_val", bus4.out_valid, 1'b1);
      chk("bp_beat_gnt", bus4.gnt, 4'b0001);
      tick();
    end
    chk("bp_end_busy", bus4.busy, 1'b0);

    // ignored contender C during B's burst
    bus4.req = 4'b0010;
    tick();
    chk("ic_gnt", bus4.gnt, 4'b0010);
    for (int b = 0; b < 4; b++) begin
      bus4.req = (b < 2) ? 4'b0110 : 4'b0010;
      #1;
      chk("ic_hold_gnt", bus4.gnt, 4'b0010);
      chk("ic_Y",        bus4.Y, 4'h9);
      tick();
    end
    chk("ic_idle", bus4.busy, 1'b0);
    tick();
    chk("ic_regnt_B", bus4.gnt, 4'b0010);
    bus4.req = 4'b0000;
    tick(); tick();

    // reset in the middle of a burst to C
    bus4.req = 4'b0100;
    tick();
    chk("mr_gnt", bus4.gnt, 4'b0100);
    tick(); tick();
    chk("mr_still", bus4.gnt, 4'b0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus4.req = 4'b1111;
    #1;
    chk("mr_gnt0",  bus4.gnt, 4'b0000);
    chk("mr_S0",    bus4.S, 2'd0);
    chk("mr_busy0", bus4.busy, 1'b0);
    chk("mr_val0",  bus4.out_valid, 1'b0);
    tick();
    chk("mr_next_A", bus4.gnt, 4'b0001);
    bus4.req = 4'b0000;

    // round-robin with MAX_BURST=2
    bus2.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 2; b++) begin
        chk("rr_gnt", bus2.gnt, 32'(4'b0001 << (g % 4)));
        chk("rr_S",   bus2.S, 32'(g % 4));
        chk("rr_val", bus2.out_valid, 1'b1);
        tick();
      end
      chk("rr_gap", bus2.busy, 1'b0);
      tick();
    end
    bus2.req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_4_arbiter_nb.md
# mux_4_arbiter_nb

Round-robin arbiter and sequencer for a shared N-bit 4-to-1 multiplexer. Four requesters compete for one downstream channel. The block grants one requester at a time, drives the mux select for a bounded burst, and passes data onward with a valid/ready handshake. It sits between the requester sources and the shared mux, and owns the mux select.

## Interface
- `N`, default 4: data width of each requester and of `Y`.
- `MAX_BURST`, default 4: maximum transfers per grant (1..15).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request per requester; bit i belongs to requester i (A=0, B=1, C=2, D=3).
- `A`, `B`, `C`, `D` input N each: requester data.
- `out_ready` input 1: downstream accepts the current beat.
- `gnt` output 4: one-hot grant, all-zero when idle.
- `S` output 2: mux select, equal to the index of the granted requester.
- `Y` output N: selected data.
- `out_valid` output 1: `Y` holds a valid beat this cycle.
- `busy` output 1: high while in BURST.

## Operation
- States: IDLE and BURST. 2-bit rotating priority pointer `ptr`. Beat counter `cnt`, 4 bits.
- **IDLE**
  - If `req` is zero, stay in IDLE.
  - Otherwise, search from index `ptr` upward, modulo 4. The first requester found with its bit set wins.
  - On the next edge: register the winner into `S`, set `gnt` one-hot, set `cnt`=0, go to BURST.
- **BURST**
  - `out_valid` = `req[S]`, combinational.
  - `Y` = the mux output for the registered `S`.
  - A transfer occurs when `out_valid && out_ready`. On a transfer, `cnt` increments.
- **Exit from BURST.** Either of these conditions causes the block to go to IDLE on that edge, clear `gnt`, and set `ptr`=`S`+1 mod 4:
  - (a) `req[S]`=0 in a cycle. No transfer occurs that cycle.
  - (b) A transfer with `cnt`==`MAX_BURST`-1.
- **Requester behaviour.** A requester must keep `req` and its data stable until its beat is accepted. Dropping `req` ends its grant.
- **Request changes during BURST.** Changes on non-granted `req` bits are ignored until the block returns to IDLE.
- **Fairness.** The most recently served requester has lowest priority at the next arbitration. With all four requesting continuously, the grant order is 0,1,2,3,0,…
- **Backpressure.** `out_ready`=0 stalls the burst indefinitely. `cnt` does not change and `Y` holds.
- **Reset.** `rst`=1 at any edge, including mid-burst, forces IDLE, `ptr`=0, `S`=0, `gnt`=0, `cnt`=0. Any beat in flight is dropped. The first arbitration after reset has requester 0 at top priority.
- **Reset values of outputs:** `gnt`=0000, `S`=00, `busy`=0, `out_valid`=0, `Y`=`A` (because `S`=0).

## Timing
- Request to grant: 1 cycle. `req` sampled in IDLE at edge k gives `gnt`/`S`/`busy` valid after edge k.
- First `out_valid` appears in the cycle after that edge if `req[S]` is still high.
- Minimum grant duration: 1 cycle.
- Burst exit to next grant:
  - 1 idle cycle, so `busy` drops for exactly one cycle between back-to-back grants.
  - The arbitration in that IDLE cycle already uses the updated `ptr`.
- Throughput with `out_ready`=1 and all requesting: `MAX_BURST` beats per `MAX_BURST`+1 cycles.
- `out_valid` and `Y` are combinational from registered `S`/state and live `req`/data. There is no extra pipeline stage.

## Structure
- Shared constants header holds:
  - state encodings `ST_IDLE`=1'b0, `ST_BURST`=1'b1;
  - requester index constants `REQ_A`..`REQ_D` = 0..3.
- Datapath: one instance of the team's `mux_4_to_1_nb` with `N` passed through. `S` drives its select; `Y` is its output.
- The rotating-priority search is a combinational function or always block local to this module. No separate sub-module.

## Test plan
- **Reset mid-burst.** Grant to C with 2 beats done, then assert `rst` for one edge. Required: `gnt`=0000, `S`=00, `busy`=0, `out_valid`=0 next cycle. Then hold `req`=1111: the next grant goes to A (0).
- **Single requester, full burst.** `req`=0010, `B`=4'h9, `out_ready`=1, `MAX_BURST`=4. Required:
  - `gnt`=0010 one cycle after `req`;
  - 4 beats of 4'h9;
  - then 1 cycle with `busy`=0;
  - then a re-grant to B.
- **Round-robin.** `req`=1111 held, `MAX_BURST`=2. Required grant sequence: 0,1,2,3,0, each with 2 beats and 1 idle cycle between grants.
- **Early release.** Grant to D, 1 beat accepted, then D drops `req` while `req[0]`=1. Required: no second beat from D; `ptr`=0; the next grant goes to A.
- **Backpressure.** Grant to A, hold `out_ready`=0 for 5 cycles. Required: `out_valid`=1, `Y`=`A` stable, `cnt` unchanged. Release `out_ready`: the burst completes the full `MAX_BURST` beats.
- **Ignored contender.** During a burst to B, assert then deassert `req[2]` before B finishes. Required: no grant to C, and `gnt` stays 0010 until B exits.
